id_hazard_scheduler: RTL and testbench
======================================

# id_hazard_scheduler

Register-hazard scheduler for the decode stage of the 5-stage pipeline. Keeps a per-register countdown scoreboard of in-flight writes, stalls decode while a source register is still pending, injects a bubble into EX, and generates the one-cycle IF flush for jumps and branches resolved in decode. The block sits beside the decode stage, replacing the address-compare stall logic, and feeds the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- HAZARD_WINDOW, 2: stall cycles for a back-to-back dependency (producer write visible in decode HAZARD_WINDOW+1 cycles after it leaves decode); legal 1..7.
- MAX_STALL, 15: consecutive stall cycles that raise hazard_timeout; legal 1..255.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state cleared while low.
- pipe_hold  in  1  global freeze (memory not ready); freezes all state.
- id_valid  in  1  decode holds a real instruction.
- id_rs_addr  in  5  rs field; id_rs_used  in  1  instruction reads rs.
- id_rt_addr  in  5  rt field; id_rt_used  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes the register file.
- id_wr_addr  in  5  destination (rd, rt or 31 already resolved).
- id_redirect  in  1  jump or taken branch resolved in decode.
- id_stall  out  1  hold PC and IF/ID.
- ex_bubble  out  1  load NOP into ID/EX.
- if_flush  out  1  squash instruction in IF/ID.
- busy_mask  out  32  bit n set when register n has a nonzero count.
- hazard_timeout  out  1  sticky watchdog flag.

## Operation
- Scoreboard: 31 counters cnt[1..31], width 3 bits; register 0 never tracked, busy_mask[0]=0.
- hazard = id_valid & ((id_rs_used & id_rs_addr!=0 & cnt[rs]!=0) | (id_rt_used & id_rt_addr!=0 & cnt[rt]!=0)).
- id_stall = pipe_hold | hazard. ex_bubble = hazard & ~pipe_hold. if_flush = id_valid & id_redirect & ~id_stall.
- issue = id_valid & ~id_stall. On issue with id_wr_en and id_wr_addr!=0: cnt[id_wr_addr] <= HAZARD_WINDOW at the edge.
- Every other nonzero counter decrements by 1 per edge unless pipe_hold=1 (all counters frozen).
- Simultaneous issue to a register whose counter is decrementing: load value wins.
- Redirect on a stalled cycle is ignored; it is re-presented when the stall clears.
- FSM states: RUN, STALL. RUN->STALL when hazard & ~pipe_hold; STALL->RUN when ~hazard; pipe_hold keeps current state. stall_run counter (8 bits) increments each STALL cycle, clears on entering RUN, saturates at 255.
- hazard_timeout sets when stall_run reaches MAX_STALL; stays 1 until reset.

## Timing
- Reset values: all cnt=0, FSM=RUN, stall_run=0, busy_mask=0, hazard_timeout=0; id_stall/ex_bubble/if_flush then depend only on inputs (0 when pipe_hold=0, id_valid=0).
- id_stall, ex_bubble, if_flush are combinational from inputs and registered state, same cycle; no registered latency.
- Producer issued at edge t: dependent in decode at t+1..t+HAZARD_WINDOW stalls; proceeds at t+HAZARD_WINDOW+1.
- busy_mask reflects counters after the edge (registered view).
- rst low mid-stall: outputs fall to reset values immediately, pending counters lost.

## Configuration
- HAZARD_STATS_EN: when defined, adds outputs stat_stall_cycles (32) and stat_flushes (32), cleared by reset, incrementing on each cycle with ex_bubble=1 and each if_flush=1, wrapping at 2^32. When undefined, ports and counters are absent; all other behaviour identical.

## Test plan
- Reset: rst=0 with random inputs -> busy_mask=0, hazard_timeout=0; release, id_valid=0 -> id_stall=0, if_flush=0.
- Back-to-back: issue write $5, next instruction reads rs=$5 -> id_stall=ex_bubble=1 for exactly 2 cycles, issues on 3rd; busy_mask[5]=1 for 2 cycles.
- $0 and unused source: write $0 then read $0; write $7 then instruction with id_rt_addr=7, id_rt_used=0 -> no stall.
- Redirect: id_redirect=1 with no hazard -> if_flush=1 one cycle; id_redirect=1 during hazard stall -> if_flush=0 until stall clears, then 1.
- pipe_hold: set cnt[9]=2, assert pipe_hold 5 cycles -> busy_mask[9] stays 1, id_stall=1, ex_bubble=0; release -> 2 more stall cycles for a $9 reader.
- Watchdog with MAX_STALL=3, HAZARD_WINDOW=7: dependency stalls 7 cycles -> hazard_timeout rises on 3rd stall cycle, stays 1 until rst=0.

Source files
------------

// File: rtl/id_hazard_if.sv
// Decode-stage hazard bus between the decode stage (master) and the hazard scheduler (slave).
// HAZARD_STATS_EN adds the stall/flush statistics outputs.
interface id_hazard_if;
    logic        pipe_hold;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic        id_rs_used;
    logic [4:0]  id_rt_addr;
    logic        id_rt_used;
    logic        id_wr_en;
    logic [4:0]  id_wr_addr;
    logic        id_redirect;
    logic        id_stall;
    logic        ex_bubble;
    logic        if_flush;
    logic [31:0] busy_mask;
    logic        hazard_timeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_flushes;

    modport master (
        output pipe_hold, id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
               id_wr_en, id_wr_addr, id_redirect,
        input  id_stall, ex_bubble, if_flush, busy_mask, hazard_timeout,
               stat_stall_cycles, stat_flushes
    );
    modport slave (
        input  pipe_hold, id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
               id_wr_en, id_wr_addr, id_redirect,
        output id_stall, ex_bubble, if_flush, busy_mask, hazard_timeout,
               stat_stall_cycles, stat_flushes
    );
`else
    modport master (
        output pipe_hold, id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
               id_wr_en, id_wr_addr, id_redirect,
        input  id_stall, ex_bubble, if_flush, busy_mask, hazard_timeout
    );
    modport slave (
        input  pipe_hold, id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
               id_wr_en, id_wr_addr, id_redirect,
        output id_stall, ex_bubble, if_flush, busy_mask, hazard_timeout
    );
`endif
endinterface

// File: rtl/id_hazard_scheduler.sv
// Decode-stage register-hazard scheduler: countdown scoreboard, stall/bubble/flush generation, stall watchdog.
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
module id_hazard_scheduler #(
    parameter int unsigned HAZARD_WINDOW = 2,
    parameter int unsigned MAX_STALL     = 15
) (
    input logic         clk,
    input logic         rst,
    id_hazard_if.slave  bus
);

    typedef enum logic {RUN, STALL} state_e;

    localparam logic [2:0] LOAD_VAL = 3'(HAZARD_WINDOW);
    localparam logic [7:0] MAX_RUN  = 8'(MAX_STALL);

    logic [2:0]  cnt [1:31];
    logic [31:0] busy;
    logic        hazard;
    logic        issue_wr;
    state_e      state_q, state_d;
    logic [7:0]  stall_run_q, stall_run_d;
    logic        timeout_q, timeout_d;

    // busy[0] is hard-wired low, so indexing with a $0 source never flags a hazard.
    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++) busy[i] = (cnt[i] != 3'd0);
    end

    assign hazard = bus.id_valid &
                    ((bus.id_rs_used & busy[bus.id_rs_addr]) |
                     (bus.id_rt_used & busy[bus.id_rt_addr]));

    assign bus.id_stall       = bus.pipe_hold | hazard;
    assign bus.ex_bubble      = hazard & ~bus.pipe_hold;
    assign bus.if_flush       = bus.id_valid & bus.id_redirect & ~bus.id_stall;
    assign bus.busy_mask      = busy;
    assign bus.hazard_timeout = timeout_q;

    assign issue_wr = bus.id_valid & ~bus.id_stall & bus.id_wr_en & (bus.id_wr_addr != 5'd0);

    // NOTE: the scoreboard is a bank of flops, not a RAM, so it must be cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) cnt[i] <= 3'd0;
        end else if (!bus.pipe_hold) begin
            for (int i = 1; i < 32; i++) begin
                if (issue_wr && bus.id_wr_addr == 5'(i)) cnt[i] <= LOAD_VAL;
                else if (cnt[i] != 3'd0)                 cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    // NOTE: every variable is given a default first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        stall_run_d = stall_run_q;
        timeout_d   = timeout_q;
        if (!bus.pipe_hold) begin
            if (hazard) begin
                state_d = STALL;
                if (stall_run_q != 8'hFF) stall_run_d = stall_run_q + 8'd1;
            end else begin
                state_d     = RUN;
                stall_run_d = 8'd0;
            end
            if (stall_run_d >= MAX_RUN) timeout_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_run_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_run_q <= stall_run_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, flushes_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flushes_q      <= 32'd0;
        end else begin
            if (bus.ex_bubble) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (bus.if_flush)  flushes_q      <= flushes_q + 32'd1;
        end
    end

    assign bus.stat_stall_cycles = stall_cycles_q;
    assign bus.stat_flushes      = flushes_q;
`endif

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Self-checking bench for id_hazard_scheduler: directed scenarios plus randomized traffic against a
// timestamp-based scoreboard model; a second instance (HAZARD_WINDOW=7, MAX_STALL=3) covers the watchdog.
module tb_id_hazard_scheduler;

    localparam int HW      = 2;
    localparam int MAXS    = 15;
    localparam int W_HW    = 7;
    localparam int W_MAXS  = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    id_hazard_if bus ();
    id_hazard_if wbus ();

    id_hazard_scheduler #(.HAZARD_WINDOW(HW), .MAX_STALL(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    id_hazard_scheduler #(.HAZARD_WINDOW(W_HW), .MAX_STALL(W_MAXS)) dut_wd (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a register is pending while fewer than HW non-held edges
    // have elapsed since the edge that issued its producer.
    int act;
    int last_issue [32];
    int run;
    bit m_timeout;

    task automatic model_reset();
        act = 0;
        for (int r = 0; r < 32; r++) last_issue[r] = -1000;
        run       = 0;
        m_timeout = 1'b0;
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && ((act - last_issue[r]) < HW);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = m_busy(r);
        return m;
    endfunction

    function automatic bit m_hazard();
        return bus.id_valid &&
               ((bus.id_rs_used && m_busy(int'(bus.id_rs_addr))) ||
                (bus.id_rt_used && m_busy(int'(bus.id_rt_addr))));
    endfunction

    task automatic model_edge();
        bit hz;
        hz = m_hazard();
        if (!bus.pipe_hold) begin
            act++;
            if (bus.id_valid && !hz && bus.id_wr_en && bus.id_wr_addr != 5'd0)
                last_issue[bus.id_wr_addr] = act;
            run = hz ? ((run < 255) ? run + 1 : 255) : 0;
            if (run >= MAXS) m_timeout = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.pipe_hold = 0; bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rs_used = 0;
        bus.id_rt_addr = 0; bus.id_rt_used = 0; bus.id_wr_en = 0; bus.id_wr_addr = 0;
        bus.id_redirect = 0;
        wbus.pipe_hold = 0; wbus.id_valid = 0; wbus.id_rs_addr = 0; wbus.id_rs_used = 0;
        wbus.id_rt_addr = 0; wbus.id_rt_used = 0; wbus.id_wr_en = 0; wbus.id_wr_addr = 0;
        wbus.id_redirect = 0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.pipe_hold = 1'($urandom); bus.id_valid = 1'($urandom);
        bus.id_rs_addr = 5'($urandom); bus.id_rs_used = 1'($urandom);
        bus.id_rt_addr = 5'($urandom); bus.id_rt_used = 1'($urandom);
        bus.id_wr_en = 1'($urandom); bus.id_wr_addr = 5'($urandom);
        bus.id_redirect = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy_mask !== 32'd0) begin
            n_fail++; $display("FAIL reset_busy_mask: got %h expected 0", bus.busy_mask);
        end
        n_checks++;
        if (bus.hazard_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus.hazard_timeout);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.id_stall !== 1'b0 || bus.if_flush !== 1'b0 || bus.ex_bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: got stall=%b flush=%b bubble=%b expected 0 0 0",
                     bus.id_stall, bus.if_flush, bus.ex_bubble);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.id_valid = 1; bus.id_wr_en = 1; bus.id_wr_addr = 5'd5;
        @(negedge clk);
        n_checks++;
        if (bus.id_stall !== 1'b0) begin
            n_fail++; $display("FAIL b2b_producer_stall: got %b expected 0", bus.id_stall);
        end
        tick();
        bus.id_wr_en = 0; bus.id_rs_addr = 5'd5; bus.id_rs_used = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.id_stall !== 1'b1 || bus.ex_bubble !== 1'b1 || bus.busy_mask[5] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_stall_cycle%0d: got stall=%b bubble=%b busy5=%b expected 1 1 1",
                         c, bus.id_stall, bus.ex_bubble, bus.busy_mask[5]);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (bus.id_stall !== 1'b0 || bus.ex_bubble !== 1'b0 || bus.busy_mask[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_proceed: got stall=%b bubble=%b busy5=%b expected 0 0 0",
                     bus.id_stall, bus.ex_bubble, bus.busy_mask[5]);
        end
        tick();
        drain(4);
    endtask

    task automatic test_zero_and_unused();
        idle();
        bus.id_valid = 1; bus.id_wr_en = 1; bus.id_wr_addr = 5'd0;
        tick();
        bus.id_wr_en = 0; bus.id_rs_addr = 5'd0; bus.id_rs_used = 1;
        @(negedge clk);
        n_checks++;
        if (bus.id_stall !== 1'b0 || bus.busy_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_reg: got stall=%b mask=%h expected 0 0", bus.id_stall, bus.busy_mask);
        end
        tick();
        bus.id_rs_used = 0; bus.id_wr_en = 1; bus.id_wr_addr = 5'd7;
        tick();
        bus.id_wr_en = 0; bus.id_rt_addr = 5'd7; bus.id_rt_used = 0;
        @(negedge clk);
        n_checks++;
        if (bus.id_stall !== 1'b0 || bus.busy_mask[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL unused_rt: got stall=%b busy7=%b expected 0 1", bus.id_stall, bus.busy_mask[7]);
        end
        tick();
        drain(4);
    endtask

    task automatic test_redirect();
        idle();
        bus.id_valid = 1; bus.id_redirect = 1;
        @(negedge clk);
        n_checks++;
        if (bus.if_flush !== 1'b1) begin
            n_fail++; $display("FAIL redirect_free: got %b expected 1", bus.if_flush);
        end
        tick();
        bus.id_valid = 0;
        @(negedge clk);
        n_checks++;
        if (bus.if_flush !== 1'b0) begin
            n_fail++; $display("FAIL redirect_one_cycle: got %b expected 0", bus.if_flush);
        end
        tick();
        bus.id_valid = 1; bus.id_redirect = 0; bus.id_wr_en = 1; bus.id_wr_addr = 5'd12;
        tick();
        bus.id_wr_en = 0; bus.id_rs_addr = 5'd12; bus.id_rs_used = 1; bus.id_redirect = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.if_flush !== 1'b0) begin
                n_fail++; $display("FAIL redirect_stalled%0d: got %b expected 0", c, bus.if_flush);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_flush !== 1'b1) begin
            n_fail++; $display("FAIL redirect_after_stall: got %b expected 1", bus.if_flush);
        end
        tick();
        drain(4);
    endtask

    task automatic test_pipe_hold();
        idle();
        bus.id_valid = 1; bus.id_wr_en = 1; bus.id_wr_addr = 5'd9;
        tick();
        bus.id_wr_en = 0; bus.id_rs_addr = 5'd9; bus.id_rs_used = 1; bus.pipe_hold = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.id_stall !== 1'b1 || bus.ex_bubble !== 1'b0 || bus.busy_mask[9] !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got stall=%b bubble=%b busy9=%b expected 1 0 1",
                         c, bus.id_stall, bus.ex_bubble, bus.busy_mask[9]);
            end
            tick();
        end
        bus.pipe_hold = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.id_stall !== (c < 2) || bus.ex_bubble !== (c < 2)) begin
                n_fail++;
                $display("FAIL hold_release%0d: got stall=%b bubble=%b expected %0d %0d",
                         c, bus.id_stall, bus.ex_bubble, c < 2, c < 2);
            end
            tick();
        end
        drain(4);
    endtask

    task automatic test_random();
        bit hz, e_stall, e_bubble, e_flush;
        for (int i = 0; i < 400; i++) begin
            bus.pipe_hold   = ($urandom_range(0, 9) == 0);
            bus.id_valid    = ($urandom_range(0, 3) != 0);
            bus.id_rs_addr  = 5'($urandom_range(0, 7));
            bus.id_rs_used  = 1'($urandom);
            bus.id_rt_addr  = 5'($urandom_range(0, 7));
            bus.id_rt_used  = 1'($urandom);
            bus.id_wr_en    = 1'($urandom);
            bus.id_wr_addr  = 5'($urandom_range(0, 7));
            bus.id_redirect = ($urandom_range(0, 4) == 0);
            hz       = m_hazard();
            e_stall  = bus.pipe_hold || hz;
            e_bubble = hz && !bus.pipe_hold;
            e_flush  = bus.id_valid && bus.id_redirect && !e_stall;
            @(negedge clk);
            n_checks++;
            if (bus.id_stall !== e_stall || bus.ex_bubble !== e_bubble || bus.if_flush !== e_flush) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got stall=%b bubble=%b flush=%b expected %b %b %b",
                         i, bus.id_stall, bus.ex_bubble, bus.if_flush, e_stall, e_bubble, e_flush);
            end
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.hazard_timeout !== m_timeout) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got mask=%h timeout=%b expected %h %b",
                         i, bus.busy_mask, bus.hazard_timeout, m_mask(), m_timeout);
            end
            tick();
        end
        drain(4);
    endtask

    task automatic test_reset_mid_stall();
        idle();
        bus.id_valid = 1; bus.id_wr_en = 1; bus.id_wr_addr = 5'd20;
        tick();
        bus.id_wr_en = 0; bus.id_rs_addr = 5'd20; bus.id_rs_used = 1;
        @(negedge clk);
        n_checks++;
        if (bus.id_stall !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got stall=%b expected 1", bus.id_stall);
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.id_stall !== 1'b0 || bus.ex_bubble !== 1'b0 || bus.busy_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got stall=%b bubble=%b mask=%h expected 0 0 0",
                     bus.id_stall, bus.ex_bubble, bus.busy_mask);
        end
        #1 rst = 1'b1;
        drain(4);
    endtask

    task automatic test_watchdog();
        idle();
        wbus.id_valid = 1; wbus.id_wr_en = 1; wbus.id_wr_addr = 5'd3;
        tick();
        wbus.id_wr_en = 0; wbus.id_rs_addr = 5'd3; wbus.id_rs_used = 1;
        for (int c = 1; c <= W_HW; c++) begin
            @(negedge clk);
            n_checks++;
            if (wbus.id_stall !== 1'b1) begin
                n_fail++; $display("FAIL wd_stall%0d: got %b expected 1", c, wbus.id_stall);
            end
            tick();
            n_checks++;
            if (wbus.hazard_timeout !== (c >= W_MAXS)) begin
                n_fail++;
                $display("FAIL wd_timeout_after%0d: got %b expected %0d", c, wbus.hazard_timeout, c >= W_MAXS);
            end
        end
        @(negedge clk);
        n_checks++;
        if (wbus.id_stall !== 1'b0) begin
            n_fail++; $display("FAIL wd_proceed: got %b expected 0", wbus.id_stall);
        end
        drain(5);
        n_checks++;
        if (wbus.hazard_timeout !== 1'b1) begin
            n_fail++; $display("FAIL wd_sticky: got %b expected 1", wbus.hazard_timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (wbus.hazard_timeout !== 1'b0) begin
            n_fail++; $display("FAIL wd_reset: got %b expected 0", wbus.hazard_timeout);
        end
        #1 rst = 1'b1;
        drain(2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_back_to_back();
        test_zero_and_unused();
        test_redirect();
        test_pipe_hold();
        test_random();
        test_reset_mid_stall();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
